dct_row_sequencer: RTL and testbench
====================================

Name: dct_row_sequencer

Overview:
Controller for the 4-lane DCT accumulation datapath (15-bit sample in, four 18-bit coefficient outputs).
- Accepts a stream of samples over a valid/ready handshake.
- Clears the lanes once per block, then drives each sample into the datapath with its index.
- Waits the datapath latency, captures all four coefficients together and presents them over a second valid/ready handshake.
- Sits between the sample source (row/column memory) and the transpose/quantiser stage.

Parameters:
SAMPLES, 8, samples per block; 2..8; index width 3 bits
DP_LAT, 2, clock edges from the datapath sampling the last sample to its outputs being stable; 1..7

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
s_valid  in  1  input sample valid
s_ready  out  1  sequencer accepts sample
s_data  in  15  input sample
flush  in  1  synchronous abort; returns to IDLE
dp_clr  out  1  clear datapath accumulators (1-cycle pulse)
dp_en  out  1  datapath sample strobe
dp_in  out  15  sample to datapath
dp_k  out  3  sample index 0..SAMPLES-1
dp_out1..dp_out4  in  18 each  datapath coefficients
res1..res4  out  18 each  captured coefficients
res_valid  out  1  results valid
res_ready  in  1  downstream accepts results
busy  out  1  state != IDLE
blk_cnt  out  8  completed blocks, wraps 255->0

Behaviour:
- Reset (async, rst=1): state IDLE. Outputs: s_ready=0, dp_clr=0, dp_en=0, dp_in=0, dp_k=0, res1..4=0, res_valid=0, busy=0, blk_cnt=0. Index and wait counters = 0.
- All outputs are registered.
- States: IDLE, CLEAR, FEED, WAIT, HOLD.
- IDLE: s_ready=0. If s_valid=1, go to CLEAR. No sample is consumed in IDLE.
- CLEAR (1 cycle): dp_clr=1 for exactly this cycle; index=0; s_ready=0. Next state FEED.
- FEED: s_ready=1.
  - On each handshake (s_valid & s_ready) at edge E: from E, for one cycle, dp_en=1, dp_in=s_data, dp_k=index. Then index increments.
  - No handshake: dp_en=0; dp_in and dp_k hold. Gaps of any length are legal.
  - When the handshake with index=SAMPLES-1 occurs, go to WAIT with s_ready=0 from that edge.
- WAIT: counts DP_LAT+1 edges after the last-sample edge. On the final one, capture dp_out1..4 into res1..4, set res_valid=1, increment blk_cnt, go to HOLD.
- HOLD: res1..4 stable and res_valid=1 until res_ready=1 at an edge. At that edge res_valid=0; next state is CLEAR if s_valid=1, else IDLE.
- res_ready while res_valid=0 is ignored.
- flush=1 at an edge in any state:
  - Go to IDLE; s_ready=0, dp_en=0, res_valid=0; index and wait counter cleared.
  - res1..4 and blk_cnt keep their values.
  - A sample presented in that cycle is not consumed.
  - flush overrides every other transition in the same cycle.
- dp_clr and dp_en are never both 1.
- Samples are delivered to the datapath in order with contiguous indices 0..SAMPLES-1. No sample is dropped or duplicated.
- blk_cnt wraps modulo 256.
- Reset mid-block aborts immediately; the partial block is discarded and no result is emitted.
- Minimum block period (s_valid and res_ready held high): 1 CLEAR + SAMPLES FEED + (DP_LAT+1) WAIT + 1 HOLD cycles. For SAMPLES=8, DP_LAT=2: 13 cycles.

Test Plan:
- Basic block: SAMPLES=8, DP_LAT=2, behavioural summing datapath model, samples 1..8 back-to-back, res_ready=1 → one dp_clr pulse; dp_k sequence 0..7; res1=36; res_valid high for 1 cycle; blk_cnt=1; busy low afterwards if s_valid=0.
- Input gaps: s_valid low for 3 cycles after samples 3 and 6 → dp_en pulses exactly 8; dp_k contiguous; same result 36; capture exactly 3 edges after the last handshake.
- Output backpressure: res_ready low for 5 cycles after res_valid rises → res1..4 and res_valid held stable all 5 cycles; s_ready=0 throughout; release → next block starts with CLEAR.
- Flush mid-FEED after 4 samples → IDLE next cycle; no res_valid; blk_cnt unchanged; the following full block 10..17 yields res1=108.
- Async reset asserted mid-WAIT, between clock edges → all outputs 0 immediately; after release, a full block completes normally.
- Wrap and throughput: 256 back-to-back blocks → blk_cnt returns to 0; each block period measures 13 cycles.

Source files
------------

// File: rtl/dct_row_sequencer_if.sv
// Signal bundle between the DCT row sequencer, its sample source, the 4-lane
// accumulation datapath and the downstream transpose/quantiser stage.
interface dct_row_sequencer_if;
    logic        s_valid;
    logic        s_ready;
    logic [14:0] s_data;
    logic        flush;
    logic        dp_clr;
    logic        dp_en;
    logic [14:0] dp_in;
    logic [2:0]  dp_k;
    logic [17:0] dp_out1;
    logic [17:0] dp_out2;
    logic [17:0] dp_out3;
    logic [17:0] dp_out4;
    logic [17:0] res1;
    logic [17:0] res2;
    logic [17:0] res3;
    logic [17:0] res4;
    logic        res_valid;
    logic        res_ready;
    logic        busy;
    logic [7:0]  blk_cnt;

    modport master (
        input  s_valid, s_data, flush, dp_out1, dp_out2, dp_out3, dp_out4, res_ready,
        output s_ready, dp_clr, dp_en, dp_in, dp_k, res1, res2, res3, res4,
               res_valid, busy, blk_cnt
    );

    modport slave (
        output s_valid, s_data, flush, dp_out1, dp_out2, dp_out3, dp_out4, res_ready,
        input  s_ready, dp_clr, dp_en, dp_in, dp_k, res1, res2, res3, res4,
               res_valid, busy, blk_cnt
    );
endinterface

// File: rtl/dct_row_sequencer.sv
// Block sequencer for the 4-lane DCT accumulation datapath: clears the lanes,
// streams indexed samples in, waits out the datapath latency, holds the result.
module dct_row_sequencer #(
    parameter int unsigned SAMPLES = 8,
    parameter int unsigned DP_LAT  = 2
) (
    input logic                 clk,
    input logic                 rst,
    dct_row_sequencer_if.master bus
);

    typedef enum logic [2:0] {IDLE, CLEAR, FEED, WAIT, HOLD} state_t;

    localparam logic [2:0] LAST_IDX  = 3'(SAMPLES - 1);
    localparam logic [2:0] LAST_WAIT = 3'(DP_LAT);

    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [2:0]  wait_q, wait_d;
    logic        s_ready_q, s_ready_d;
    logic        dp_clr_q, dp_clr_d;
    logic        dp_en_q, dp_en_d;
    logic [14:0] dp_in_q, dp_in_d;
    logic [2:0]  dp_k_q, dp_k_d;
    logic [17:0] res1_q, res1_d;
    logic [17:0] res2_q, res2_d;
    logic [17:0] res3_q, res3_d;
    logic [17:0] res4_q, res4_d;
    logic        res_valid_q, res_valid_d;
    logic        busy_q, busy_d;
    logic [7:0]  blk_cnt_q, blk_cnt_d;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        wait_d      = wait_q;
        s_ready_d   = 1'b0;
        dp_clr_d    = 1'b0;
        dp_en_d     = 1'b0;
        dp_in_d     = dp_in_q;
        dp_k_d      = dp_k_q;
        res1_d      = res1_q;
        res2_d      = res2_q;
        res3_d      = res3_q;
        res4_d      = res4_q;
        res_valid_d = res_valid_q;
        blk_cnt_d   = blk_cnt_q;

        if (bus.flush) begin
            state_d     = IDLE;
            idx_d       = '0;
            wait_d      = '0;
            res_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.s_valid) begin
                        state_d  = CLEAR;
                        dp_clr_d = 1'b1;
                        idx_d    = '0;
                    end
                end
                CLEAR: begin
                    state_d   = FEED;
                    s_ready_d = 1'b1;
                end
                FEED: begin
                    s_ready_d = 1'b1;
                    if (bus.s_valid && s_ready_q) begin
                        dp_en_d = 1'b1;
                        dp_in_d = bus.s_data;
                        dp_k_d  = idx_q;
                        if (idx_q == LAST_IDX) begin
                            state_d   = WAIT;
                            s_ready_d = 1'b0;
                            idx_d     = '0;
                            wait_d    = '0;
                        end else begin
                            idx_d = idx_q + 3'd1;
                        end
                    end
                end
                WAIT: begin
                    // Final count lands DP_LAT+1 edges after the last sample edge.
                    if (wait_q == LAST_WAIT) begin
                        state_d     = HOLD;
                        wait_d      = '0;
                        res1_d      = bus.dp_out1;
                        res2_d      = bus.dp_out2;
                        res3_d      = bus.dp_out3;
                        res4_d      = bus.dp_out4;
                        res_valid_d = 1'b1;
                        blk_cnt_d   = blk_cnt_q + 8'd1;
                    end else begin
                        wait_d = wait_q + 3'd1;
                    end
                end
                HOLD: begin
                    if (bus.res_ready) begin
                        res_valid_d = 1'b0;
                        if (bus.s_valid) begin
                            state_d  = CLEAR;
                            dp_clr_d = 1'b1;
                            idx_d    = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            wait_q      <= '0;
            s_ready_q   <= 1'b0;
            dp_clr_q    <= 1'b0;
            dp_en_q     <= 1'b0;
            dp_in_q     <= '0;
            dp_k_q      <= '0;
            res1_q      <= '0;
            res2_q      <= '0;
            res3_q      <= '0;
            res4_q      <= '0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            blk_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            wait_q      <= wait_d;
            s_ready_q   <= s_ready_d;
            dp_clr_q    <= dp_clr_d;
            dp_en_q     <= dp_en_d;
            dp_in_q     <= dp_in_d;
            dp_k_q      <= dp_k_d;
            res1_q      <= res1_d;
            res2_q      <= res2_d;
            res3_q      <= res3_d;
            res4_q      <= res4_d;
            res_valid_q <= res_valid_d;
            busy_q      <= busy_d;
            blk_cnt_q   <= blk_cnt_d;
        end
    end

    assign bus.s_ready   = s_ready_q;
    assign bus.dp_clr    = dp_clr_q;
    assign bus.dp_en     = dp_en_q;
    assign bus.dp_in     = dp_in_q;
    assign bus.dp_k      = dp_k_q;
    assign bus.res1      = res1_q;
    assign bus.res2      = res2_q;
    assign bus.res3      = res3_q;
    assign bus.res4      = res4_q;
    assign bus.res_valid = res_valid_q;
    assign bus.busy      = busy_q;
    assign bus.blk_cnt   = blk_cnt_q;

endmodule

// File: tb/tb_dct_row_sequencer.sv
// Bench for dct_row_sequencer: behavioural 4-lane summing datapath plus a
// transaction-level reference that predicts handshakes, results and counts.
module tb_dct_row_sequencer;

    localparam int unsigned SAMPLES = 8;
    localparam int unsigned DP_LAT  = 2;
    localparam int unsigned PD      = DP_LAT - 1;
    localparam int unsigned PERIOD  = 1 + SAMPLES + (DP_LAT + 1) + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dct_row_sequencer_if bus();

    dct_row_sequencer #(.SAMPLES(SAMPLES), .DP_LAT(DP_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Lane k-weighting: lane1 plain sum, lanes 2-4 weighted by sample index.
    function automatic logic [17:0] term(input int j, input logic [14:0] x, input logic [2:0] k);
        int unsigned xv;
        int unsigned kv;
        xv = 32'(x);
        kv = 32'(k);
        case (j)
            0:       return 18'(xv);
            1:       return 18'(xv * (kv + 1));
            2:       return 18'(xv * (SAMPLES - kv));
            default: return 18'(xv << kv);
        endcase
    endfunction

    logic [17:0] acc  [4];
    logic [17:0] pipe [PD][4];

    always @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < 4; j++) begin
                acc[j] <= '0;
                for (int s = 0; s < int'(PD); s++) pipe[s][j] <= '0;
            end
        end else begin
            for (int j = 0; j < 4; j++) begin
                if (bus.dp_clr)     acc[j] <= '0;
                else if (bus.dp_en) acc[j] <= acc[j] + term(j, bus.dp_in, bus.dp_k);
                pipe[0][j] <= acc[j];
                for (int s = 1; s < int'(PD); s++) pipe[s][j] <= pipe[s-1][j];
            end
        end
    end

    assign bus.dp_out1 = pipe[PD-1][0];
    assign bus.dp_out2 = pipe[PD-1][1];
    assign bus.dp_out3 = pipe[PD-1][2];
    assign bus.dp_out4 = pipe[PD-1][3];

    // Reference model state, sampled on the falling edge.
    int          cyc = 0;
    int          cnt = 0;
    int unsigned k_exp = 0;
    bit          pend = 0;
    logic [14:0] pend_d;
    logic [2:0]  pend_k;
    bit          rv_exp = 0;
    logic [17:0] res_exp [4];
    logic [17:0] nxt_res [4];
    logic [7:0]  blk_exp = '0;
    logic [14:0] blk [$];
    int          en_cnt = 0, clr_cnt = 0, rv_cyc = 0;
    int          last_clr = -1;
    bit          tp_on = 0;

    always @(negedge clk) begin
        logic [17:0] got [4];
        cyc++;
        got[0] = bus.res1; got[1] = bus.res2; got[2] = bus.res3; got[3] = bus.res4;
        if (rst) begin
            cnt = 0; pend = 0; k_exp = 0; rv_exp = 0; blk_exp = '0;
            blk.delete();
            for (int j = 0; j < 4; j++) res_exp[j] = '0;
        end else begin
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    rv_exp = 1;
                    for (int j = 0; j < 4; j++) res_exp[j] = nxt_res[j];
                    blk_exp = blk_exp + 8'd1;
                end
            end
            chk_eq("res_valid", 32'(bus.res_valid), 32'(rv_exp));
            for (int j = 0; j < 4; j++) chk_eq($sformatf("res%0d", j + 1), 32'(got[j]), 32'(res_exp[j]));
            chk_eq("blk_cnt", 32'(bus.blk_cnt), 32'(blk_exp));
            chk_eq("dp_en", 32'(bus.dp_en), 32'(pend));
            if (pend) begin
                chk_eq("dp_in", 32'(bus.dp_in), 32'(pend_d));
                chk_eq("dp_k", 32'(bus.dp_k), 32'(pend_k));
            end
            chk_eq("clr_en_excl", 32'(bus.dp_clr & bus.dp_en), 32'd0);
            if (bus.res_valid) chk_eq("s_ready_in_hold", 32'(bus.s_ready), 32'd0);

            if (bus.dp_en) en_cnt++;
            if (bus.res_valid) rv_cyc++;
            if (bus.dp_clr) begin
                clr_cnt++;
                if (tp_on && last_clr >= 0) chk_eq("blk_period", 32'(cyc - last_clr), 32'(PERIOD));
                last_clr = tp_on ? cyc : -1;
            end

            if (bus.flush) begin
                cnt = 0; pend = 0; k_exp = 0; rv_exp = 0;
                blk.delete();
            end else begin
                if (rv_exp && bus.res_ready) rv_exp = 0;
                pend = bus.s_valid && bus.s_ready;
                if (pend) begin
                    pend_d = bus.s_data;
                    pend_k = 3'(k_exp);
                    blk.push_back(bus.s_data);
                    k_exp++;
                    if (k_exp == SAMPLES) begin
                        for (int j = 0; j < 4; j++) begin
                            nxt_res[j] = '0;
                            for (int i = 0; i < blk.size(); i++)
                                nxt_res[j] = nxt_res[j] + term(j, blk[i], 3'(i));
                        end
                        blk.delete();
                        k_exp = 0;
                        cnt = DP_LAT + 2;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Feeds n samples (first<0: random values), optional gap after samples ga/gb.
    task automatic send(input int n, input int first, input int ga, input int gb,
                        input int glen, input bit keep);
        for (int i = 0; i < n; i++) begin
            int t;
            bit hs;
            t  = 0;
            hs = 0;
            bus.s_valid = 1'b1;
            bus.s_data  = (first < 0) ? 15'($urandom) : 15'(first + i);
            while (!hs) begin
                hs = bus.s_ready;
                tick();
                t++;
                if (!hs && t > 100) begin
                    chk_eq("hs_timeout", 32'(bus.s_ready), 32'd1);
                    hs = 1;
                end
            end
            if (i + 1 == ga || i + 1 == gb) begin
                bus.s_valid = 1'b0;
                repeat (glen) tick();
            end
        end
        if (!keep) bus.s_valid = 1'b0;
    endtask

    task automatic wait_rv();
        int t;
        t = 0;
        while (bus.res_valid !== 1'b1 && t < 60) begin
            tick();
            t++;
        end
        chk_eq("rv_timeout", 32'(bus.res_valid), 32'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk_eq({tag, "_s_ready"}, 32'(bus.s_ready), 32'd0);
        chk_eq({tag, "_dp_clr"}, 32'(bus.dp_clr), 32'd0);
        chk_eq({tag, "_dp_en"}, 32'(bus.dp_en), 32'd0);
        chk_eq({tag, "_dp_in"}, 32'(bus.dp_in), 32'd0);
        chk_eq({tag, "_dp_k"}, 32'(bus.dp_k), 32'd0);
        chk_eq({tag, "_res"}, 32'(bus.res1 | bus.res2 | bus.res3 | bus.res4), 32'd0);
        chk_eq({tag, "_res_valid"}, 32'(bus.res_valid), 32'd0);
        chk_eq({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk_eq({tag, "_blk_cnt"}, 32'(bus.blk_cnt), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, c0, r0;
        bus.s_valid = 1'b0;
        bus.s_data = '0;
        bus.flush = 1'b0;
        bus.res_ready = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        chk_all_zero("reset");
        rst = 1'b0;
        tick();

        // basic block 1..8
        bus.res_ready = 1'b1;
        e0 = en_cnt; c0 = clr_cnt; r0 = rv_cyc;
        send(8, 1, 0, 0, 0, 0);
        wait_rv();
        repeat (4) tick();
        chk_eq("basic_res1", 32'(bus.res1), 32'd36);
        chk_eq("basic_en_pulses", 32'(en_cnt - e0), 32'd8);
        chk_eq("basic_clr_pulses", 32'(clr_cnt - c0), 32'd1);
        chk_eq("basic_rv_cycles", 32'(rv_cyc - r0), 32'd1);
        chk_eq("basic_blk_cnt", 32'(bus.blk_cnt), 32'd1);
        chk_eq("basic_busy_idle", 32'(bus.busy), 32'd0);

        // input gaps after samples 3 and 6
        e0 = en_cnt;
        send(8, 1, 3, 6, 3, 0);
        wait_rv();
        repeat (3) tick();
        chk_eq("gap_res1", 32'(bus.res1), 32'd36);
        chk_eq("gap_en_pulses", 32'(en_cnt - e0), 32'd8);
        chk_eq("gap_blk_cnt", 32'(bus.blk_cnt), 32'd2);

        // output backpressure with the next block waiting
        bus.res_ready = 1'b0;
        send(8, -1, 0, 0, 0, 1);
        wait_rv();
        repeat (5) begin
            tick();
            chk_eq("bp_hold_rv", 32'(bus.res_valid), 32'd1);
            chk_eq("bp_s_ready", 32'(bus.s_ready), 32'd0);
        end
        bus.res_ready = 1'b1;
        tick();
        chk_eq("bp_next_clr", 32'(bus.dp_clr), 32'd1);
        chk_eq("bp_rv_drop", 32'(bus.res_valid), 32'd0);
        send(8, -1, 0, 0, 0, 0);
        wait_rv();
        repeat (3) tick();
        chk_eq("bp_blk_cnt", 32'(bus.blk_cnt), 32'd4);

        // flush after 4 samples, with a sample offered during the flush
        send(4, -1, 0, 0, 0, 1);
        bus.flush = 1'b1;
        bus.s_data = 15'($urandom);
        tick();
        bus.flush = 1'b0;
        bus.s_valid = 1'b0;
        chk_eq("flush_busy", 32'(bus.busy), 32'd0);
        chk_eq("flush_s_ready", 32'(bus.s_ready), 32'd0);
        chk_eq("flush_dp_en", 32'(bus.dp_en), 32'd0);
        r0 = rv_cyc;
        repeat (5) tick();
        chk_eq("flush_no_result", 32'(rv_cyc - r0), 32'd0);
        chk_eq("flush_blk_cnt", 32'(bus.blk_cnt), 32'd4);
        send(8, 10, 0, 0, 0, 0);
        wait_rv();
        repeat (3) tick();
        chk_eq("flush_next_res1", 32'(bus.res1), 32'd108);
        chk_eq("flush_next_blk", 32'(bus.blk_cnt), 32'd5);

        // asynchronous reset in WAIT, between clock edges
        send(8, -1, 0, 0, 0, 0);
        tick();
        #2 rst = 1'b1;
        #1 chk_all_zero("async_rst");
        tick();
        rst = 1'b0;
        r0 = rv_cyc;
        repeat (5) tick();
        chk_eq("async_no_result", 32'(rv_cyc - r0), 32'd0);
        send(8, -1, 0, 0, 0, 0);
        wait_rv();
        repeat (3) tick();
        chk_eq("async_after_blk", 32'(bus.blk_cnt), 32'd1);

        // 256 back-to-back blocks: wrap and throughput
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        tp_on = 1;
        for (int b = 0; b < 256; b++) send(8, -1, 0, 0, 0, 1);
        bus.s_valid = 1'b0;
        wait_rv();
        repeat (3) tick();
        tp_on = 0;
        chk_eq("wrap_blk_cnt", 32'(bus.blk_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
